// File: rtl/wisard_pkg.sv
// Shared WiSARD constants and serializer state encodings.
// Counter width covers address widths up to 32.
package wisard_pkg;

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SHIFT      = 2'd1,
    SHIFT_HELD = 2'd2
  } state_e;

endpackage

// File: rtl/wisard_hold_reg.sv
// One-entry valid/ready holding register.
// Push and pop never coincide: in_ready is low while full.
module wisard_hold_reg #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         full;
  logic [W-1:0] data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (in_valid && !full) begin
      full <= 1'b1;
      data <= in_data;
    end else if (out_ready && full) begin
      full <= 1'b0;
    end
  end

  assign in_ready  = !full;
  assign out_valid = full;
  assign out_data  = data;

endmodule

// File: rtl/wisard_addr_serializer.sv
// Parallel-to-serial WiSARD address serializer, LSB first.
// One shifter plus one hold entry; back-to-back words have no gap.
module wisard_addr_serializer
  import wisard_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sink_valid,
  output logic                     sink_ready,
  input  logic                     sop,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  output logic                     src_valid,
  output logic                     src_sop,
  output logic                     src_addr,
  output logic                     busy
);

  localparam int HW = ADDRESS_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(ADDRESS_WIDTH - 1);

  state_e                   state_q;
  state_e                   state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [ADDRESS_WIDTH-1:0] sh_q;
  logic                     accept;
  logic                     last;
  logic                     bypass;
  logic                     pop;
  logic                     load;
  logic                     hold_in_ready;
  logic                     hold_out_valid;
  logic [HW-1:0]            hold_q;
  logic [HW-1:0]            load_w;

  wisard_hold_reg #(
    .W(HW)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (accept && !bypass),
    .in_ready (hold_in_ready),
    .in_data  ({sop, addr}),
    .out_valid(hold_out_valid),
    .out_ready(pop),
    .out_data (hold_q)
  );

  assign sink_ready = (state_q != SHIFT_HELD) && hold_in_ready;
  assign accept     = sink_valid && sink_ready;
  assign last       = (state_q != IDLE) && (cnt_q == CNT_LAST);
  assign load       = bypass || pop;
  assign load_w     = pop ? hold_q : {sop, addr};

  always_comb begin
    state_d = state_q;
    bypass  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          bypass  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last) begin
          bypass  = accept;
          state_d = accept ? SHIFT : IDLE;
        end else if (accept) begin
          state_d = SHIFT_HELD;
        end
      end
      SHIFT_HELD: begin
        if (last) begin
          pop     = hold_out_valid;
          state_d = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // cnt_q is the index of the bit currently on src_addr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= CNT_ZERO;
      sh_q      <= '0;
      src_addr  <= 1'b0;
      src_valid <= 1'b0;
      src_sop   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      if (load) begin
        sh_q      <= load_w[ADDRESS_WIDTH-1:0] >> 1;
        src_addr  <= load_w[0];
        src_valid <= 1'b1;
        src_sop   <= load_w[HW-1];
        cnt_q     <= CNT_ZERO;
      end else if (state_q != IDLE && !last) begin
        sh_q      <= sh_q >> 1;
        src_addr  <= sh_q[0];
        src_valid <= 1'b0;
        src_sop   <= 1'b0;
        cnt_q     <= cnt_q + CNT_ONE;
      end else begin
        src_addr  <= 1'b0;
        src_valid <= 1'b0;
        src_sop   <= 1'b0;
        cnt_q     <= CNT_ZERO;
      end
    end
  end

endmodule

// File: doc/wisard_addr_serializer.md
WISARD_ADDR_SERIALIZER -- requirements
Module: wisard_addr_serializer

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 5, number of address bits per word; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port sink_valid  input  1  parallel word offered this cycle.
REQ-005 SHALL have port sink_ready  output  1  block can accept a word this cycle.
REQ-006 SHALL have port sop  input  1  offered word is first of a frame; sampled only on acceptance.
REQ-007 SHALL have port addr  input  ADDRESS_WIDTH  parallel address word.
REQ-008 SHALL have port src_valid  output  1  strobe marking the first serial bit of a word.
REQ-009 SHALL have port src_sop  output  1  frame-start flag, high in the same cycle as src_valid for a word accepted with sop=1.
REQ-010 SHALL have port src_addr  output  1  serial address bit.
REQ-011 SHALL have port busy  output  1  a word is shifting or held.

Function
REQ-012 A word SHALL be accepted on a cycle with sink_valid=1 and sink_ready=1; sop and addr are captured with it.
REQ-013 Storage SHALL be one shift register plus one holding register (capacity two words); sink_ready = holding register empty, registered-free combinational from state.
REQ-014 Serialisation SHALL be LSB first: addr[0] in the first output cycle, addr[k] in output cycle k, ADDRESS_WIDTH consecutive cycles, no gaps.
REQ-015 src_valid SHALL be high only in the addr[0] cycle; src_sop only in that cycle and only if the word carried sop=1.
REQ-016 All outputs except sink_ready SHALL be registered; a word accepted at cycle T into an idle shifter SHALL emit addr[0] at T+1.
REQ-017 Bit counter SHALL run 0..ADDRESS_WIDTH-1 (5-bit, covers 32) and wrap to 0 after the last bit.
REQ-018 When the shifter emits its last bit and a word is pending (held or accepted that same cycle), the next word's addr[0] with src_valid SHALL follow in the very next cycle (zero-gap back-to-back).
REQ-019 States: IDLE (nothing stored), SHIFT (shifter active, hold empty), SHIFT_HELD (shifter active, hold full); SHIFT_HELD at last bit moves hold into shifter -> SHIFT.
REQ-020 Acceptance in the same cycle the hold register empties SHALL be allowed only when sink_ready was high that cycle; no word is ever dropped or overwritten.
REQ-021 src_addr SHALL be 0 and src_valid/src_sop 0 in every non-shifting cycle.
REQ-022 busy SHALL be high in SHIFT and SHIFT_HELD, low in IDLE.
REQ-023 sop SHALL not alter any word other than the one accepted with it.

Reset
REQ-024 rst_n low SHALL immediately clear shifter, hold register, counter and state to IDLE; src_valid, src_sop, src_addr, busy = 0; sink_ready = 1.
REQ-025 Reset mid-word SHALL abort the word with no further bits emitted; first word after release starts at addr[0].

Structure
REQ-026 ADDR_ZERO-style width constants and state encodings (IDLE/SHIFT/SHIFT_HELD) SHALL live in the shared wisard package.
REQ-027 One sub-module SHALL be natural: wisard_hold_reg, the one-entry valid/ready holding register for {sop, addr}.
REQ-028 Output format SHALL match the existing WiSARD serial address receiver: loopback through it reproduces addr and sop exactly.

Verification
REQ-029 W=5, accept addr=5'b10110, sop=1 at T -> src_addr 0,1,1,0,1 at T+1..T+5; src_valid and src_sop high only at T+1.
REQ-030 sink_valid held high with words 5'h03, 5'h1C, 5'h15 -> 15 contiguous bits, src_valid at T+1, T+6, T+11; sink_ready low while hold full.
REQ-031 Word offered while SHIFT_HELD -> sink_ready=0, word not taken, accepted the cycle hold drains, no loss.
REQ-032 rst_n pulsed low at bit 3 of a word -> outputs 0 at once, sink_ready=1; next word 5'h11 emits 1,0,0,0,1 cleanly.
REQ-033 W=32, 1000 random words with random sop and random sink_valid gaps looped into the receiver -> every addr and sop reproduced in order.
